// File: rtl/dmem_dma.sv
// Block-copy DMA master for the word-addressed data memory (combinational read, clocked write).
// Copies LEN words SRC->DST with memmove semantics, one READ and one WRITE cycle per word.
module dmem_dma #(
  parameter int unsigned SIZE = 32,
  parameter int unsigned AW   = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [AW-1:0]   SRC,
  input  logic [AW-1:0]   DST,
  input  logic [AW:0]     LEN,
  input  logic [SIZE-1:0] RD,
  output logic [AW-1:0]   A,
  output logic            WE,
  output logic [SIZE-1:0] WD,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERR
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW+1:0] DepthX = (AW+2)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StFin, StFault} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            back_q, back_d;
  logic [SIZE-1:0] hold_q, hold_d;

  logic [AW+1:0] src_end, dst_end;
  logic          range_err, backward;
  logic [AW-1:0] src_last, dst_last;

  // Extended-width sums so LEN=DEPTH near the top of memory cannot alias.
  assign src_end   = {2'b00, SRC} + {1'b0, LEN};
  assign dst_end   = {2'b00, DST} + {1'b0, LEN};
  assign range_err = (src_end > DepthX) || (dst_end > DepthX);
  assign backward  = (DST > SRC) && ({2'b00, DST} < src_end);
  // Modulo-2^AW arithmetic; only reached for in-range transfers, where it is exact.
  assign src_last  = SRC + LEN[AW-1:0] - AW'(1);
  assign dst_last  = DST + LEN[AW-1:0] - AW'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      back_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      back_q  <= back_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    back_d  = back_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          if (range_err) begin
            state_d = StFault;
          end else if (LEN == '0) begin
            state_d = StFin;
          end else begin
            back_d  = backward;
            src_d   = backward ? src_last : SRC;
            dst_d   = backward ? dst_last : DST;
            cnt_d   = LEN;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        hold_d  = RD;
        state_d = StWrite;
      end
      StWrite: begin
        src_d   = back_q ? src_q - AW'(1) : src_q + AW'(1);
        dst_d   = back_q ? dst_q - AW'(1) : dst_q + AW'(1);
        cnt_d   = cnt_q - (AW+1)'(1);
        state_d = (cnt_q == (AW+1)'(1)) ? StFin : StRead;
      end
      StFin:   state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    A = '0;
    unique case (state_q)
      StRead:  A = src_q;
      StWrite: A = dst_q;
      default: A = '0;
    endcase
  end

  assign WE   = (state_q == StWrite);
  assign WD   = hold_q;
  assign BUSY = (state_q == StRead) || (state_q == StWrite);
  assign DONE = (state_q == StFin);
  assign ERR  = (state_q == StFault);

endmodule

// File: tb/tb_dmem_dma.sv
// Self-checking bench for dmem_dma: behavioural memory, memmove reference model,
// write scoreboard, table-driven transfers plus hand-written corner sequences.
module tb_dmem_dma;
  localparam int AW    = 6;
  localparam int SIZE  = 32;
  localparam int DEPTH = 64;

  logic            CLK = 1'b0;
  logic            RST, START;
  logic [AW-1:0]   SRC, DST, A;
  logic [AW:0]     LEN;
  logic [SIZE-1:0] RD, WD;
  logic            WE, BUSY, DONE, ERR;
  logic            load;

  always #5 CLK = ~CLK;

  dmem_dma #(.SIZE(SIZE), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SRC(SRC), .DST(DST), .LEN(LEN), .RD(RD),
    .A(A), .WE(WE), .WD(WD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [SIZE-1:0] data;
  } wr_t;

  typedef struct {
    int    src;
    int    dst;
    int    len;
    bit    err;
    bit    back;
    string name;
  } vec_t;

  wr_t             exp_q[$];
  wr_t             mon_e;
  logic [SIZE-1:0] mem     [DEPTH];
  logic [SIZE-1:0] exp_mem [DEPTH];
  vec_t            vecs[$];
  int              errors = 0;
  int              checks = 0;

  function automatic logic [SIZE-1:0] pat(input int i);
    if (i < 4) return SIZE'((i + 1) * 11);
    if (i >= 5 && i <= 8) return SIZE'(i - 4);
    return 32'hC0DE_0000 + SIZE'(i * 257);
  endfunction

  assign RD = mem[A];
  always @(posedge CLK) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (WE) begin
      mem[A] <= WD;
    end
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Every write strobe must match the next expected write, in order.
  always @(negedge CLK) begin
    if (WE) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_write", 64'({A, WD}), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk(A == mon_e.addr && WD == mon_e.data, "write", 64'({A, WD}), 64'(mon_e));
      end
    end
  end

  // Reference memmove on a snapshot; order follows the expected copy direction.
  task automatic prep(input int src, input int dst, input int len, input bit back,
                      input int nmax);
    logic [SIZE-1:0] snap [DEPTH];
    for (int i = 0; i < DEPTH; i++) snap[i] = exp_mem[i];
    for (int i = 0; i < len && i < nmax; i++) begin
      int  j;
      wr_t e;
      j      = back ? len - 1 - i : i;
      e.addr = AW'(dst + j);
      e.data = snap[src + j];
      exp_q.push_back(e);
      exp_mem[dst + j] = snap[src + j];
    end
  endtask

  task automatic mem_chk(input string name);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk(bad == 0, {name, "_mem"}, 64'(bad), 64'(0));
    chk(exp_q.size() == 0, {name, "_writes_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  // Returns at the negedge of cycle 1 after the accepting edge.
  task automatic kick(input int src, input int dst, input int len);
    @(negedge CLK);
    chk(!BUSY && !DONE && !ERR, "idle_before_start", 64'({BUSY, DONE, ERR}), 64'(0));
    START = 1'b1;
    SRC   = AW'(src);
    DST   = AW'(dst);
    LEN   = (AW+1)'(len);
    @(negedge CLK);
    START = 1'b0;
    SRC   = AW'($urandom);
    DST   = AW'($urandom);
    LEN   = (AW+1)'($urandom);
  endtask

  task automatic run(input vec_t v);
    int busy_n = 0;
    int end_k  = 0;
    bit got_done = 1'b0;
    bit got_err  = 1'b0;
    if (!v.err) prep(v.src, v.dst, v.len, v.back, DEPTH + 1);
    kick(v.src, v.dst, v.len);
    for (int k = 1; k <= 300; k++) begin
      busy_n += int'(BUSY);
      if (DONE || ERR) begin
        end_k    = k;
        got_done = DONE;
        got_err  = ERR;
        break;
      end
      @(negedge CLK);
    end
    chk(end_k != 0, {v.name, "_timeout"}, 64'(end_k), 64'(1));
    if (v.err)
      chk(got_err && !got_done && end_k == 1 && busy_n == 0, {v.name, "_err_timing"},
          64'({got_err, got_done, 16'(end_k), 16'(busy_n)}), 64'({2'b10, 16'(1), 16'(0)}));
    else
      chk(got_done && !got_err && end_k == 2 * v.len + 1 && busy_n == 2 * v.len,
          {v.name, "_done_timing"}, 64'({got_done, got_err, 16'(end_k), 16'(busy_n)}),
          64'({2'b10, 16'(2 * v.len + 1), 16'(2 * v.len)}));
    mem_chk(v.name);
  endtask

  initial begin
    int nd, dk;
    RST = 1'b1; START = 1'b0; SRC = '0; DST = '0; LEN = '0; load = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = pat(i);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    load = 1'b0;
    chk(A == 0 && !WE && WD == 0 && !BUSY && !DONE && !ERR, "reset_state",
        64'({A, WE, WD, BUSY, DONE, ERR}), 64'(0));
    RST = 1'b0;

    // Runs are issued back to back: each START lands the cycle after DONE/ERR.
    vecs.push_back('{0,  10, 4,  1'b0, 1'b0, "fwd"});
    vecs.push_back('{5,  7,  4,  1'b0, 1'b1, "overlap_back"});
    vecs.push_back('{3,  4,  0,  1'b0, 1'b0, "zero_len"});
    vecs.push_back('{60, 0,  5,  1'b1, 1'b0, "src_range"});
    vecs.push_back('{0,  63, 1,  1'b0, 1'b0, "dst_top"});
    vecs.push_back('{0,  62, 3,  1'b1, 1'b0, "dst_range"});
    vecs.push_back('{12, 10, 5,  1'b0, 1'b0, "overlap_fwd"});
    vecs.push_back('{1,  0,  64, 1'b1, 1'b0, "len_max_range"});
    vecs.push_back('{20, 23, 4,  1'b0, 1'b1, "overlap_edge"});
    vecs.push_back('{20, 24, 4,  1'b0, 1'b0, "adjacent"});
    vecs.push_back('{60, 59, 4,  1'b0, 1'b0, "top_end"});
    vecs.push_back('{30, 30, 5,  1'b0, 1'b0, "self_copy"});
    vecs.push_back('{0,  0,  64, 1'b0, 1'b0, "full_self"});
    foreach (vecs[i]) run(vecs[i]);

    // START while busy must be ignored.
    prep(30, 40, 3, 1'b0, DEPTH);
    kick(30, 40, 3);
    @(negedge CLK);
    START = 1'b1; SRC = 6'd20; DST = 6'd50; LEN = 7'd2;
    @(negedge CLK);
    START = 1'b0;
    nd = 0; dk = 0;
    for (int k = 3; k <= 15; k++) begin
      if (DONE) begin nd++; dk = k; end
      @(negedge CLK);
    end
    chk(nd == 1 && dk == 7, "busy_start_done", 64'({16'(nd), 16'(dk)}),
        64'({16'(1), 16'(7)}));
    mem_chk("busy_start");

    // Reset during the READ after the second WRITE of a 4-word copy.
    prep(0, 20, 4, 1'b0, 2);
    kick(0, 20, 4);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk(!WE && !BUSY && A == 0, "rst_mid_outputs", 64'({WE, BUSY, A}), 64'(0));
    nd = 0;
    repeat (10) begin
      nd += int'(DONE);
      @(negedge CLK);
    end
    chk(nd == 0, "rst_mid_no_done", 64'(nd), 64'(0));
    mem_chk("rst_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_dma.md
Name: dmem_dma

Overview:
- Block-copy initiator on the word-addressed data-memory port. It is the master side of the CLK/WE/A/WD/RD interface.
- On a START pulse it copies LEN 32-bit words from word address SRC to word address DST, using the memory's combinational read and clocked write.
- It sits beside the pipelined CPU's memory stage. BUSY selects the DMA's A/WE/WD over the CPU's in the external port mux.
- Typical use: moving picture/text buffers without CPU load/store loops.

Parameters:
- SIZE, 32, data word width (matches memory word).
- AW, 6, word-address width; memory depth DEPTH = 2**AW = 64 words.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- START  input  1  one-cycle request, sampled only in IDLE.
- SRC  input  AW  source start word address.
- DST  input  AW  destination start word address.
- LEN  input  AW+1  word count, 0..DEPTH.
- RD  input  SIZE  memory read data, combinational from A.
- A  output  AW  memory word address.
- WE  output  1  memory write enable.
- WD  output  SIZE  memory write data.
- BUSY  output  1  DMA owns memory port.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  one-cycle range-error pulse.

Behaviour:
- Reset (RST=1 at a rising edge): state goes to IDLE and all internal registers clear. After that edge, A=0, WE=0, WD=0, BUSY=0, DONE=0, ERR=0.
- Reset mid-transfer: WE drops in the cycle after the reset edge. Words already written stay written; there is no rollback.
- States: IDLE, READ, WRITE, FIN, FAULT. All outputs are decoded from registered state and pointers only; there is no combinational path from START to outputs.
- IDLE: A=0, WE=0, BUSY=0. On an edge with START=1:
  - If SRC+LEN > DEPTH or DST+LEN > DEPTH (compute in AW+2 bits): go to FAULT.
  - Else if LEN=0: go to FIN.
  - Else: load pointers and count=LEN, then go to READ.
- Direction: backward copy when DST > SRC and DST < SRC+LEN (overlap hazard). Otherwise forward.
  - Forward: pointers start at SRC and DST, then +1 per word.
  - Backward: pointers start at SRC+LEN-1 and DST+LEN-1, then -1 per word.
  - Result equals memmove semantics.
- READ: A=src_ptr, WE=0, BUSY=1. At the edge, hold<=RD; go to WRITE.
- WRITE: A=dst_ptr, WE=1, WD=hold, BUSY=1. At the edge, the memory stores the word, pointers step, and count decrements.
  - If count was 1: go to FIN.
  - Else: go to READ.
- FIN: DONE=1 for exactly one cycle, BUSY=0, WE=0; then IDLE.
- FAULT: ERR=1 for exactly one cycle, no memory access; then IDLE.
- WD outside WRITE holds its last value; it is don't-care to the memory because WE=0.
- Latency: N words take 2N cycles in READ/WRITE. DONE is high in cycle 2N+1 after the START edge; a new START is accepted the cycle after DONE.
- START while not in IDLE is ignored; it is not queued.
- SRC, DST and LEN are sampled only at the accepting edge. Later changes have no effect.
- Pointer arithmetic is AW bits. Range checking guarantees no wrap-around occurs during a legal transfer.
- LEN=DEPTH with SRC=DST=0 is legal: a full self-copy, 128 busy cycles.

Test Plan:
- Forward copy: mem[0..3]=11,22,33,44, START SRC=0 DST=10 LEN=4 -> 8 BUSY cycles, WE pulses at A=10,11,12,13 with WD=11,22,33,44, DONE in cycle 9, mem[0..3] unchanged.
- Overlap backward: mem[5..8]=1,2,3,4, SRC=5 DST=7 LEN=4 -> write order A=10,9,8,7, final mem[7..10]=1,2,3,4.
- Zero length and range: LEN=0 -> DONE next cycle, no WE. SRC=60 LEN=5 -> ERR one cycle, no WE, BUSY never high. DST=63 LEN=1 -> legal, one word written.
- Start while busy: second START (SRC=20) during a LEN=3 transfer -> ignored, only the original 3 words move, one DONE pulse.
- Reset mid-op: RST at the edge after the second WRITE of a LEN=4 copy -> next cycle WE=0, BUSY=0, A=0. Exactly 2 destination words are modified, and no DONE pulse is produced.
- Back-to-back: START asserted the cycle after DONE -> accepted, second copy completes correctly.
